fifo_read_ctrl: RTL and testbench

//  Read-domain controller of the async FIFO; counterpart of the write-side pointer/full logic.

---
 rtl/fifo_rd_if.sv | 11 +
 rtl/fifo_read_ctrl.sv | 97 +++++++++
 tb/tb_fifo_read_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_if.sv
// Consumer-side read handshake of the async FIFO: first-word-fall-through valid/ready.
interface fifo_rd_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_valid;
  logic                  rdata_ready;

  modport master (output rdata, output rdata_valid, input rdata_ready);
  modport slave  (input rdata, input rdata_valid, output rdata_ready);
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-domain side of the async FIFO: synchronises the write pointer, owns the read pointer,
// fetches from the dual-port memory and presents words through a 2-entry FWFT output stage.
module fifo_read_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rclken,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  fifo_rd_if.master             rd,
  output logic                  mem_empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH+1:0] rd_level
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW:0] AE_LVL = (PW+1)'(AE_THRESH);

  logic [PW-1:0]         rq1_wptr, rq2_wptr, rbin, rbin_next, rgray_next, wbin_sync, mem_words;
  logic                  pending, pop, fetch;
  logic [1:0]            cnt;
  logic [2:0]            occ;
  logic [DATA_WIDTH-1:0] head, skid;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq1_wptr <= '0;
      rq2_wptr <= '0;
    end else begin
      rq1_wptr <= wptr_gray;
      rq2_wptr <= rq1_wptr;
    end
  end

  // Fetch only if the word will have a stage slot once it lands next cycle.
  always_comb begin
    pop        = rd.rdata_valid & rd.rdata_ready;
    occ        = {1'b0, cnt} + {2'b0, pending} - {2'b0, pop};
    fetch      = ~mem_empty & (occ < 3'd2);
    rbin_next  = rbin + {{(PW-1){1'b0}}, fetch};
    rgray_next = (rbin_next >> 1) ^ rbin_next;
  end

  assign rclken = fetch;
  assign raddr  = rbin[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin      <= '0;
      rptr      <= '0;
      mem_empty <= 1'b1;
      pending   <= 1'b0;
    end else begin
      rbin      <= rbin_next;
      rptr      <= rgray_next;
      mem_empty <= (rgray_next == rq2_wptr);
      pending   <= fetch;
    end
  end

  // Output stage: head is always the oldest word; skid only fills behind a held head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      head <= '0;
      skid <= '0;
    end else begin
      cnt <= cnt + {1'b0, pending} - {1'b0, pop};
      if (pop && cnt == 2'd2) begin
        head <= skid;
        if (pending) skid <= mem_rdata;
      end else if (pending) begin
        if (cnt == 2'd0 || pop) head <= mem_rdata;
        else                    skid <= mem_rdata;
      end
    end
  end

  assign rd.rdata       = head;
  assign rd.rdata_valid = (cnt != 2'd0);

  assign wbin_sync    = gray2bin(rq2_wptr);
  assign mem_words    = wbin_sync - rbin;
  assign rd_level     = {1'b0, mem_words} + {{PW{1'b0}}, pending} + {{(PW-1){1'b0}}, cnt};
  assign almost_empty = (rd_level <= AE_LVL);
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: memory model plus write-side stub, scoreboard checked on every pop.
module tb_fifo_read_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] wptr_gray, rptr;
  logic [5:0] raddr;
  logic       rclken, mem_empty, almost_empty;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] rd_level;

  logic [7:0] mem [64];
  logic [6:0] wbin;
  logic [6:0] prev_rptr = '0;
  logic [7:0] sb [$];
  int n_chk = 0, n_bad = 0, n_pop = 0, n_fetch = 0;

  fifo_rd_if #(.DATA_WIDTH(8)) rd_if ();

  fifo_read_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .AE_THRESH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wptr_gray(wptr_gray), .rptr(rptr), .raddr(raddr),
    .rclken(rclken), .mem_rdata(mem_rdata), .rd(rd_if), .mem_empty(mem_empty),
    .almost_empty(almost_empty), .rd_level(rd_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rclken) mem_rdata <= mem[raddr];

  function automatic logic [6:0] gray(input logic [6:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [6:0] g2b(input logic [6:0] g);
    logic [6:0] b;
    b[6] = g[6];
    for (int i = 5; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr_word(input logic [7:0] d);
    mem[wbin[5:0]] = d;
    sb.push_back(d);
    wbin = wbin + 7'd1;
    wptr_gray = gray(wbin);
  endtask

  // Monitor: sampled between negedge drive and the next posedge.
  always @(negedge clk) begin
    logic [7:0] exp;
    #2;
    if (rst_n) begin
      if (rclken) n_fetch++;
      if (rd_if.rdata_valid && rd_if.rdata_ready) begin
        n_pop++;
        if (sb.size() == 0) chk("sb_empty_pop", 32'(sb.size()), 1);
        else begin
          exp = sb.pop_front();
          chk("rdata", 32'(rd_if.rdata), 32'(exp));
        end
      end
      if (rptr != prev_rptr) chk("rptr_1bit", 32'($countones(rptr ^ prev_rptr)), 1);
    end
    prev_rptr = rptr;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, f0, run, maxrun, nw, space;
    rst_n = 1'b0; wptr_gray = '0; wbin = '0; rd_if.rdata_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(rd_if.rdata_valid), 0);
    chk("rst_rptr", 32'(rptr), 0);
    chk("rst_empty", 32'(mem_empty), 1);
    chk("rst_rclken", 32'(rclken), 0);
    chk("rst_level", 32'(rd_level), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    rst_n = 1'b1;
    tick();

    // first word latency
    wr_word(8'hA5);
    tick(); chk("fw_empty1", 32'(mem_empty), 1);
    tick(); chk("fw_empty2", 32'(mem_empty), 1);
    tick(); chk("fw_empty3", 32'(mem_empty), 0);
    chk("fw_rclken", 32'(rclken), 1);
    chk("fw_raddr", 32'(raddr), 0);
    tick(); chk("fw_rclken_off", 32'(rclken), 0);
    chk("fw_valid_early", 32'(rd_if.rdata_valid), 0);
    tick(); chk("fw_valid", 32'(rd_if.rdata_valid), 1);
    chk("fw_rdata", 32'(rd_if.rdata), 32'hA5);
    chk("fw_level", 32'(rd_level), 1);
    rd_if.rdata_ready = 1'b1;
    tick(); rd_if.rdata_ready = 1'b0;
    chk("fw_drained", 32'(rd_if.rdata_valid), 0);
    chk("fw_pops", n_pop, 1);

    // backpressure
    f0 = n_fetch;
    for (int i = 0; i < 3; i++) begin wr_word(8'h10 + 8'(i)); tick(); end
    repeat (8) tick();
    chk("bp_fetch", n_fetch - f0, 2);
    chk("bp_rclken", 32'(rclken), 0);
    chk("bp_level", 32'(rd_level), 3);
    chk("bp_empty", 32'(mem_empty), 0);
    chk("bp_valid", 32'(rd_if.rdata_valid), 1);
    p0 = n_pop;
    rd_if.rdata_ready = 1'b1;
    repeat (3) tick();
    chk("bp_pops", n_pop - p0, 3);
    chk("bp_sb", sb.size(), 0);
    chk("bp_valid_end", 32'(rd_if.rdata_valid), 0);
    rd_if.rdata_ready = 1'b0;

    // asynchronous reset with both stage entries full
    for (int i = 0; i < 3; i++) begin wr_word(8'h20 + 8'(i)); tick(); end
    repeat (8) tick();
    chk("mr_level_pre", 32'(rd_level), 3);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(rd_if.rdata_valid), 0);
    chk("mr_rptr", 32'(rptr), 0);
    chk("mr_level", 32'(rd_level), 0);
    chk("mr_empty", 32'(mem_empty), 1);
    chk("mr_rclken", 32'(rclken), 0);
    chk("mr_ae", 32'(almost_empty), 1);
    sb.delete(); wbin = '0; wptr_gray = '0;
    tick(); tick(); rst_n = 1'b1; tick();

    // streaming a full memory at 1 word/clk
    rd_if.rdata_ready = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 64; i++) wr_word(8'($urandom));
    tick(); tick();
    chk("st_level_full", 32'(rd_level), 64);
    run = 0; maxrun = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (rclken) begin run++; if (run > maxrun) maxrun = run; end
      else run = 0;
    end
    chk("st_run", maxrun, 64);
    chk("st_pops", n_pop - p0, 64);
    chk("st_rptr", 32'(rptr), 32'b1100000);
    chk("st_empty", 32'(mem_empty), 1);

    // wrap: 200 words in random bursts under random backpressure
    nw = 0; p0 = n_pop;
    for (int c = 0; c < 4000 && (nw < 200 || sb.size() != 0); c++) begin
      rd_if.rdata_ready = ($urandom_range(0, 3) != 0);
      if (nw < 200 && $urandom_range(0, 1) == 1) begin
        for (int k = $urandom_range(1, 8); k > 0; k--) begin
          space = 64 - int'(7'(wbin - g2b(rptr)));
          if (nw < 200 && space > 0) begin wr_word(8'($urandom)); nw++; end
        end
      end
      tick();
    end
    rd_if.rdata_ready = 1'b0;
    repeat (4) tick();
    chk("wr_sb", sb.size(), 0);
    chk("wr_pops", n_pop - p0, 200);
    chk("wr_rptr", 32'(rptr), 32'(gray(wbin)));
    chk("wr_empty", 32'(mem_empty), 1);
    chk("wr_level", 32'(rd_level), 0);

    // almost_empty threshold crossings
    for (int i = 0; i < 6; i++) wr_word(8'h40 + 8'(i));
    repeat (6) tick();
    chk("fl_level6", 32'(rd_level), 6);
    chk("fl_ae6", 32'(almost_empty), 0);
    rd_if.rdata_ready = 1'b1; tick(); rd_if.rdata_ready = 1'b0;
    chk("fl_level5", 32'(rd_level), 5);
    chk("fl_ae5", 32'(almost_empty), 0);
    rd_if.rdata_ready = 1'b1; tick(); rd_if.rdata_ready = 1'b0;
    chk("fl_level4", 32'(rd_level), 4);
    chk("fl_ae4", 32'(almost_empty), 1);
    wr_word(8'h4F);
    repeat (3) tick();
    chk("fl_level5b", 32'(rd_level), 5);
    chk("fl_ae5b", 32'(almost_empty), 0);
    rd_if.rdata_ready = 1'b1;
    for (int c = 0; c < 50 && (rd_if.rdata_valid || sb.size() != 0); c++) tick();
    tick();
    chk("dr_valid", 32'(rd_if.rdata_valid), 0);
    chk("dr_empty", 32'(mem_empty), 1);
    chk("dr_level", 32'(rd_level), 0);
    chk("dr_ae", 32'(almost_empty), 1);
    chk("dr_sb", sb.size(), 0);
    rd_if.rdata_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
